// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, select codes
// and the decoded-instruction record passed from mcc_decode to the FSM.
package mcc_pkg;
  localparam int MCC_OP_W    = 6;
  localparam int MCC_ALUOP_W = 3;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  localparam logic [MCC_OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [MCC_OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [MCC_OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [MCC_OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [MCC_OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [MCC_OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [MCC_OP_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [MCC_OP_W-1:0] OP_SW   = 6'b100110;
  localparam logic [MCC_OP_W-1:0] OP_LW   = 6'b100111;
  localparam logic [MCC_OP_W-1:0] OP_BEQ  = 6'b110000;
  localparam logic [MCC_OP_W-1:0] OP_BNE  = 6'b110001;
  localparam logic [MCC_OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [MCC_OP_W-1:0] OP_JR   = 6'b111001;
  localparam logic [MCC_OP_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [MCC_OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [MCC_ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [MCC_ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [MCC_ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [MCC_ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [MCC_ALUOP_W-1:0] ALU_AND = 3'b100;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  // Instruction class picks the state path; the rest are static datapath selects.
  typedef enum logic [2:0] {
    CLS_ALU, CLS_LW, CLS_SW, CLS_BR, CLS_JMP, CLS_HALT, CLS_NOP
  } cls_t;

  typedef struct packed {
    cls_t                   cls;
    logic                   alusrca;
    logic                   alusrcb;
    logic                   extsel;
    logic [MCC_ALUOP_W-1:0] aluop;
    logic                   alum2reg;
    logic [1:0]             regdst;
    logic                   wrpcsrc;
    logic [1:0]             jsrc;
    logic                   bne;
  } dec_t;
endpackage

// File: rtl/mcc_decode.sv
// Combinational opcode decode: instruction class plus the static datapath selects.
module mcc_decode
  import mcc_pkg::*;
(
  input  logic [MCC_OP_W-1:0] op,
  output dec_t                dec
);
  always_comb begin
    dec     = '0;
    dec.cls = CLS_NOP;
    case (op)
      OP_ADD:  begin dec.cls = CLS_ALU; dec.regdst = RD_RD; end
      OP_SUB:  begin dec.cls = CLS_ALU; dec.regdst = RD_RD; dec.aluop = ALU_SUB; end
      OP_ADDI: begin dec.cls = CLS_ALU; dec.regdst = RD_RT; dec.alusrcb = 1'b1; dec.extsel = 1'b1; end
      OP_OR:   begin dec.cls = CLS_ALU; dec.regdst = RD_RD; dec.aluop = ALU_OR; end
      OP_AND:  begin dec.cls = CLS_ALU; dec.regdst = RD_RD; dec.aluop = ALU_AND; end
      OP_ORI:  begin dec.cls = CLS_ALU; dec.regdst = RD_RT; dec.alusrcb = 1'b1; dec.aluop = ALU_OR; end
      OP_SLL:  begin dec.cls = CLS_ALU; dec.regdst = RD_RD; dec.alusrca = 1'b1; dec.aluop = ALU_SLL; end
      OP_SW:   begin dec.cls = CLS_SW; dec.alusrcb = 1'b1; dec.extsel = 1'b1; end
      OP_LW:   begin
        dec.cls = CLS_LW; dec.alusrcb = 1'b1; dec.extsel = 1'b1;
        dec.alum2reg = 1'b1; dec.regdst = RD_RT;
      end
      OP_BEQ:  begin dec.cls = CLS_BR; dec.extsel = 1'b1; dec.aluop = ALU_SUB; end
      OP_BNE:  begin dec.cls = CLS_BR; dec.extsel = 1'b1; dec.aluop = ALU_SUB; dec.bne = 1'b1; end
      OP_J:    begin dec.cls = CLS_JMP; dec.jsrc = PC_JMP; end
      OP_JR:   begin dec.cls = CLS_JMP; dec.jsrc = PC_RS; end
      OP_JAL:  begin
        dec.cls = CLS_JMP; dec.jsrc = PC_JMP; dec.wrpcsrc = 1'b1; dec.regdst = RD_RA;
      end
      OP_HALT: dec.cls = CLS_HALT;
      default: ;
    endcase
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: walks IF/ID/EXE/MEM/WB per instruction class and
// drives the datapath strobes combinationally from (state, opCode, zero).
module multi_cycle_ctrl
  import mcc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opCode,
  input  logic               zero,
  output logic [2:0]         state,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RD,
  output logic               WR,
  output logic               ALUM2Reg,
  output logic [1:0]         RegDst,
  output logic               WrPCSrc,
  output logic               RegWre,
  output logic [1:0]         PCSrc,
  output logic               halted
);
  state_t st, st_nxt;
  dec_t   dec;
  logic   last, taken;

  mcc_decode u_dec (.op(opCode), .dec(dec));

  assign taken = dec.bne ? ~zero : zero;

  // Final state of each path; the PC is loaded exactly there.
  always_comb begin
    last = 1'b0;
    case (st)
      S_ID:    last = (dec.cls == CLS_JMP) || (dec.cls == CLS_NOP);
      S_EXE:   last = (dec.cls == CLS_BR);
      S_MEM:   last = (dec.cls == CLS_SW);
      S_WB:    last = 1'b1;
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    st_nxt = S_IF;
    case (st)
      S_IF:  st_nxt = S_ID;
      S_ID:  begin
        if (dec.cls == CLS_HALT) st_nxt = S_ID;
        else if (dec.cls == CLS_JMP || dec.cls == CLS_NOP) st_nxt = S_IF;
        else st_nxt = S_EXE;
      end
      S_EXE: begin
        case (dec.cls)
          CLS_ALU:        st_nxt = S_WB;
          CLS_LW, CLS_SW: st_nxt = S_MEM;
          default:        st_nxt = S_IF;
        endcase
      end
      S_MEM:   st_nxt = (dec.cls == CLS_LW) ? S_WB : S_IF;
      default: st_nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) st <= S_IF;
    else       st <= st_nxt;
  end

  // Write strobes are masked during the reset cycle so an abandoned instruction leaves no trace.
  always_comb begin
    state    = st;
    halted   = !Reset && (st == S_ID) && (dec.cls == CLS_HALT);
    PCWre    = !Reset && last;
    IRWre    = !Reset && (st == S_IF);
    InsMemRW = (st == S_IF);
    RegWre   = !Reset && ((st == S_WB) || (st == S_ID && dec.cls == CLS_JMP && dec.wrpcsrc));
    RD       = !Reset && (st == S_MEM) && (dec.cls == CLS_LW);
    WR       = !Reset && (st == S_MEM) && (dec.cls == CLS_SW);
    PCSrc    = PC_SEQ;
    if (st == S_ID && dec.cls == CLS_JMP)             PCSrc = dec.jsrc;
    else if (st == S_EXE && dec.cls == CLS_BR && taken) PCSrc = PC_BR;
    ALUSrcA  = dec.alusrca;
    ALUSrcB  = dec.alusrcb;
    ExtSel   = dec.extsel;
    ALUOp    = dec.aluop;
    ALUM2Reg = dec.alum2reg;
    RegDst   = dec.regdst;
    WrPCSrc  = dec.wrpcsrc;
  end
endmodule
